// File: rtl/ddr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// ddr_burst_arbiter - DDR3 command-port arbiter: ingress write bursts and
// OFDM read bursts over a beat-addressed ring buffer. Stats: DDR_ARB_STATS_EN
// Revision: 1.0
// ============================================================================
module ddr_burst_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int BURST_LEN    = 64,
   parameter int RING_BEATS   = 1024,
   parameter int START_THRESH = 256,
   parameter int MAX_WR_RUN   = 4,
   parameter int BASE_ADDR    = 0,
   parameter int ADDR_SHIFT   = 3
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          init_calib_complete,
   input  logic                          wr_req,
   input  logic                          rd_req,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic                          cmd_wr,
   output logic [ADDR_W-1:0]             cmd_addr,
   input  logic                          burst_done,
   output logic                          wr_grant,
   output logic                          rd_grant,
   output logic [$clog2(RING_BEATS):0]   fill_level,
   output logic                          ring_full,
   output logic                          rd_armed,
   output logic                          underrun,
   output logic [31:0]                   stat_wr_bursts,
   output logic [31:0]                   stat_rd_bursts,
   output logic [15:0]                   stat_underruns
);

   localparam int PTR_W  = $clog2(RING_BEATS);
   localparam int FILL_W = PTR_W + 1;
   localparam int RUN_W  = $clog2(MAX_WR_RUN + 1);

   localparam logic [FILL_W-1:0] BURST_F  = FILL_W'(BURST_LEN);
   localparam logic [FILL_W-1:0] FULL_F   = FILL_W'(RING_BEATS);
   localparam logic [FILL_W-1:0] THRESH_F = FILL_W'(START_THRESH);
   localparam logic [FILL_W-1:0] WR_LIMIT = FILL_W'(RING_BEATS - BURST_LEN);
   localparam logic [PTR_W-1:0]  BURST_P  = PTR_W'(BURST_LEN);
   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_WR_RUN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMD  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [RUN_W-1:0] wr_run;
   logic             wr_ok;
   logic             rd_ok;
   logic             pick_wr;
   logic             pick_rd;
   logic             done;
   logic             drain_empty;

   assign wr_ok   = wr_req && (fill_level <= WR_LIMIT);
   assign rd_ok   = rd_req && rd_armed && (fill_level >= BURST_F);
   // Writes win unless a read is eligible and the write run is exhausted.
   assign pick_wr = init_calib_complete && wr_ok && !(rd_ok && (wr_run == RUN_MAX));
   assign pick_rd = init_calib_complete && !pick_wr && rd_ok;
   assign done    = (state == S_DATA) && burst_done;
   assign drain_empty = done && !cmd_wr && (fill_level == BURST_F);
   assign ring_full   = (fill_level == FULL_F);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pick_wr || pick_rd) state_nxt = S_CMD;
         S_CMD:   if (cmd_ready)          state_nxt = S_DATA;
         S_DATA:  if (burst_done)         state_nxt = S_IDLE;
         default:                         state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_valid = (state == S_CMD);
      wr_grant  = (state == S_DATA) && cmd_wr;
      rd_grant  = (state == S_DATA) && !cmd_wr;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cmd_wr     <= 1'b0;
         cmd_addr   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_run     <= '0;
         fill_level <= '0;
         rd_armed   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if ((state == S_IDLE) && (pick_wr || pick_rd)) begin
            cmd_wr   <= pick_wr;
            cmd_addr <= ADDR_W'(BASE_ADDR) + (ADDR_W'(pick_wr ? wr_ptr : rd_ptr) << ADDR_SHIFT);
            if (pick_rd)                wr_run <= '0;
            else if (wr_run != RUN_MAX) wr_run <= wr_run + 1'b1;
         end
         // Arming uses the post-burst level so the very next IDLE decision sees it.
         if (done) begin
            if (cmd_wr) begin
               wr_ptr     <= wr_ptr + BURST_P;
               fill_level <= fill_level + BURST_F;
               if ((fill_level + BURST_F) >= THRESH_F) rd_armed <= 1'b1;
            end else begin
               rd_ptr     <= rd_ptr + BURST_P;
               fill_level <= fill_level - BURST_F;
               if (drain_empty) begin
                  rd_armed <= 1'b0;
                  underrun <= 1'b1;
               end
            end
         end
      end
   end

`ifdef DDR_ARB_STATS_EN
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stat_wr_bursts <= '0;
         stat_rd_bursts <= '0;
         stat_underruns <= '0;
      end else begin
         if (done && cmd_wr && (stat_wr_bursts != '1))
            stat_wr_bursts <= stat_wr_bursts + 1'b1;
         if (done && !cmd_wr && (stat_rd_bursts != '1))
            stat_rd_bursts <= stat_rd_bursts + 1'b1;
         if (drain_empty && (stat_underruns != '1))
            stat_underruns <= stat_underruns + 1'b1;
      end
   end
`else
   assign stat_wr_bursts = '0;
   assign stat_rd_bursts = '0;
   assign stat_underruns = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ddr_burst_arbiter - vector table, directed corner sequences and random
// bursts checked against a transaction-level ring model. Revision: 1.0
// ============================================================================
module tb_ddr_burst_arbiter;

   localparam int ADDR_W = 28;
   localparam int BURST  = 64;
   localparam int RING   = 1024;
   localparam int THRESH = 256;
   localparam int MAXRUN = 4;
   localparam int BASE   = 32'h0010_0000;
   localparam int SHIFT  = 3;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic              calib;
   logic              wr_req;
   logic              rd_req;
   logic              cmd_ready;
   logic              burst_done;
   logic              cmd_valid;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic              wr_grant;
   logic              rd_grant;
   logic [10:0]       fill_level;
   logic              ring_full;
   logic              rd_armed;
   logic              underrun;
   logic [31:0]       stw;
   logic [31:0]       str;
   logic [15:0]       stu;

   int checks = 0;
   int errors = 0;

   // Ring model: plain beat arithmetic
   int m_fill, m_wptr, m_rptr, m_run, m_wcnt, m_rcnt, m_ucnt;
   bit m_armed;

   ddr_burst_arbiter #(
      .ADDR_W(ADDR_W), .BURST_LEN(BURST), .RING_BEATS(RING), .START_THRESH(THRESH),
      .MAX_WR_RUN(MAXRUN), .BASE_ADDR(BASE), .ADDR_SHIFT(SHIFT)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(calib),
      .wr_req(wr_req), .rd_req(rd_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .burst_done(burst_done),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .fill_level(fill_level),
      .ring_full(ring_full), .rd_armed(rd_armed), .underrun(underrun),
      .stat_wr_bursts(stw), .stat_rd_bursts(str), .stat_underruns(stu)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_fill = 0; m_wptr = 0; m_rptr = 0; m_run = 0;
      m_wcnt = 0; m_rcnt = 0; m_ucnt = 0; m_armed = 1'b0;
   endfunction

   task automatic chk_all_zero(input string name);
      chk(name, {cmd_valid, cmd_wr, cmd_addr, wr_grant, rd_grant, fill_level,
                 ring_full, rd_armed, underrun, stw, str, stu}, '0);
   endtask

   task automatic check_status(input bit exp_und);
      chk("fill_level", fill_level, m_fill);
      chk("ring_full", ring_full, m_fill == RING);
      chk("rd_armed", rd_armed, m_armed);
      chk("underrun", underrun, exp_und);
`ifdef DDR_ARB_STATS_EN
      chk("stat_wr", stw, m_wcnt);
      chk("stat_rd", str, m_rcnt);
      chk("stat_und", stu, m_ucnt);
`else
      chk("stat_zero", {stw, str, stu}, '0);
`endif
   endtask

   task automatic do_reset();
      sys_rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      cmd_ready = 1'b0; burst_done = 1'b0; calib = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      @(negedge sys_clk);
   endtask

   // One arbitration opportunity, entered at a negedge with the DUT idle.
   // obs: 0 no command, 1 write, 2 read (as seen on the DUT).
   task automatic burst(input bit w, input bit r, input bit cal, input int rdy_dly,
                        input int done_dly, output int obs, output logic [ADDR_W-1:0] oaddr);
      bit wok, rok, und;
      int exp_dir;
      logic [ADDR_W-1:0] exp_addr;
      wr_req = w; rd_req = r; calib = cal; cmd_ready = 1'b0; burst_done = 1'b0;
      wok = w && (m_fill <= RING - BURST);
      rok = r && m_armed && (m_fill >= BURST);
      if (!cal)                              exp_dir = 0;
      else if (wok && !(rok && m_run == MAXRUN)) exp_dir = 1;
      else if (rok)                          exp_dir = 2;
      else                                   exp_dir = 0;
      obs = 0; oaddr = '0;
      if (exp_dir == 0) begin
         repeat (4) begin
            @(negedge sys_clk);
            chk("no_cmd", cmd_valid, 1'b0);
         end
         return;
      end
      exp_addr = ADDR_W'(BASE) + ADDR_W'((exp_dir == 1 ? m_wptr : m_rptr) * (1 << SHIFT));
      for (int n = 0; n < 4 && !cmd_valid; n++) @(negedge sys_clk);
      chk("cmd_valid", cmd_valid, 1'b1);
      if (!cmd_valid) return;
      obs = cmd_wr ? 1 : 2;
      oaddr = cmd_addr;
      chk("cmd_wr", cmd_wr, exp_dir == 1);
      chk("cmd_addr", cmd_addr, exp_addr);
      for (int i = 0; i < rdy_dly; i++) begin
         burst_done = (i == 0);
         @(negedge sys_clk);
         chk("cmd_hold", {cmd_valid, cmd_wr, cmd_addr}, {1'b1, exp_dir == 1, exp_addr});
      end
      burst_done = 1'b0;
      cmd_ready = 1'b1;
      @(negedge sys_clk);
      cmd_ready = 1'($urandom_range(0, 1));
      chk("cmd_valid_drop", cmd_valid, 1'b0);
      chk("grant", {wr_grant, rd_grant}, (exp_dir == 1) ? 2'b10 : 2'b01);
      calib = ($urandom_range(0, 3) != 0);
      repeat (done_dly) @(negedge sys_clk);
      burst_done = 1'b1;
      @(negedge sys_clk);
      burst_done = 1'b0; cmd_ready = 1'b0;
      und = 1'b0;
      if (exp_dir == 1) begin
         m_fill += BURST; m_wptr = (m_wptr + BURST) % RING;
         m_run = (m_run < MAXRUN) ? m_run + 1 : MAXRUN; m_wcnt++;
         if (m_fill >= THRESH) m_armed = 1'b1;
      end else begin
         m_fill -= BURST; m_rptr = (m_rptr + BURST) % RING;
         m_run = 0; m_rcnt++;
         if (m_fill == 0) begin m_armed = 1'b0; und = 1'b1; m_ucnt++; end
      end
      chk("grant_off", {wr_grant, rd_grant}, 2'b00);
      check_status(und);
   endtask

   typedef struct {
      bit w;
      bit r;
      int exp_dir;
      int exp_fill;
      bit exp_armed;
   } vec_t;

   initial begin
      vec_t tbl[10];
      int obs;
      int seen;
      logic [ADDR_W-1:0] oaddr;

      tbl[0] = '{1, 1, 1,  64, 0};
      tbl[1] = '{1, 1, 1, 128, 0};
      tbl[2] = '{1, 1, 1, 192, 0};
      tbl[3] = '{1, 1, 1, 256, 1};
      tbl[4] = '{1, 1, 2, 192, 1};
      tbl[5] = '{1, 1, 1, 256, 1};
      tbl[6] = '{1, 1, 1, 320, 1};
      tbl[7] = '{1, 1, 1, 384, 1};
      tbl[8] = '{1, 1, 1, 448, 1};
      tbl[9] = '{1, 1, 2, 384, 1};

      // Reset state and calibration gating
      sys_rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; cmd_ready = 1'b0;
      burst_done = 1'b0; calib = 1'b0;
      #1;
      chk_all_zero("reset_outputs");
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      wr_req = 1'b1;
      seen = 0;
      repeat (50) begin
         @(negedge sys_clk);
         if (cmd_valid) seen++;
      end
      chk("calib_hold", seen, 0);
      calib = 1'b1;
      for (int n = 0; n < 3 && !cmd_valid; n++) @(negedge sys_clk);
      chk("calib_cmd", {cmd_valid, cmd_wr, cmd_addr}, {1'b1, 1'b1, ADDR_W'(BASE)});
      seen = 0;
      repeat (10) begin
         @(negedge sys_clk);
         if (!(cmd_valid && cmd_wr && cmd_addr == ADDR_W'(BASE))) seen++;
      end
      chk("ready_low_stable", seen, 0);
      cmd_ready = 1'b1;
      @(negedge sys_clk);
      cmd_ready = 1'b0;
      chk("first_wr_grant", {cmd_valid, wr_grant, rd_grant}, 3'b010);
      burst_done = 1'b1;
      @(negedge sys_clk);
      burst_done = 1'b0;
      chk("first_fill", fill_level, 64);

      // Second write aborted by async reset in its data phase
      for (int n = 0; n < 4 && !cmd_valid; n++) @(negedge sys_clk);
      chk("second_addr", cmd_addr, ADDR_W'(BASE + 64 * 8));
      cmd_ready = 1'b1;
      @(negedge sys_clk);
      cmd_ready = 1'b0;
      chk("second_grant", wr_grant, 1'b1);
      #2 sys_rst = 1'b1;
      #1;
      chk_all_zero("async_reset_outputs");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      burst(1, 0, 1, 1, 1, obs, oaddr);
      chk("post_reset_addr", {obs[1:0], oaddr}, {2'd1, ADDR_W'(BASE)});

      // Write/read interleave from empty
      do_reset();
      foreach (tbl[i]) begin
         burst(tbl[i].w, tbl[i].r, 1, i % 3, i % 4, obs, oaddr);
         chk("tbl_dir", obs, tbl[i].exp_dir);
         chk("tbl_fill", fill_level, tbl[i].exp_fill);
         chk("tbl_armed", rd_armed, tbl[i].exp_armed);
      end
`ifdef DDR_ARB_STATS_EN
      chk("tbl_stats", {stw, str}, {32'd8, 32'd2});
`else
      chk("tbl_stats", {stw, str, stu}, '0);
`endif

      // Fill to full, no 17th write, then wrap
      do_reset();
      for (int i = 0; i < 16; i++) burst(1, 0, 1, i % 2, 0, obs, oaddr);
      chk("full_level", {fill_level, ring_full}, {11'd1024, 1'b1});
      burst(1, 0, 1, 0, 0, obs, oaddr);
      chk("no_17th", obs, 0);
      burst(1, 1, 1, 0, 1, obs, oaddr);
      chk("full_read", {obs[1:0], oaddr}, {2'd2, ADDR_W'(BASE)});
      burst(1, 0, 1, 0, 1, obs, oaddr);
      chk("wrap_write", {obs[1:0], oaddr}, {2'd1, ADDR_W'(BASE)});

      // Prefill to threshold then drain to underrun
      do_reset();
      for (int i = 0; i < 4; i++) burst(1, 0, 1, 0, 0, obs, oaddr);
      for (int i = 0; i < 4; i++) burst(0, 1, 1, 1, 2, obs, oaddr);
      chk("drain_end", {fill_level, rd_armed, underrun}, {11'd0, 1'b0, 1'b1});
      @(negedge sys_clk);
      chk("underrun_width", underrun, 1'b0);
      burst(0, 1, 1, 0, 0, obs, oaddr);
      chk("no_read_after_underrun", obs, 0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         burst($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 92, $urandom_range(0, 3),
               $urandom_range(0, 3), obs, oaddr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
